// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arith ops, iterative multiply/divide,
// valid/ready handshake on both sides.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALU_Sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALU_Out,
  output logic             CarryOut,
  output logic             Zero,
  output logic             DivZero
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam int CW = $clog2(WIDTH);

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic               op_div;
  logic [WIDTH-1:0]   opnd;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_nx;

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     dif;
  logic [WIDTH-1:0]   res;
  logic               cy;
  logic               dz;
  logic               is_long;

  logic [WIDTH:0]     upper;
  logic [WIDTH:0]     sh;
  logic [WIDTH:0]     diff;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  assign sum = {1'b0, A} + {1'b0, B};
  assign dif = {1'b0, A} - {1'b0, B};

  assign is_long = (ALU_Sel == 4'b0010) ||
                   ((ALU_Sel == 4'b0011) && (B != '0));

  always_comb begin
    res = '0;
    cy  = 1'b0;
    dz  = 1'b0;
    unique case (ALU_Sel)
      4'b0000: begin res = sum[WIDTH-1:0]; cy = sum[WIDTH]; end
      4'b0001: begin res = dif[WIDTH-1:0]; cy = dif[WIDTH]; end
      4'b0010: res = '0;
      // only reaches DONE directly when dividing by zero
      4'b0011: begin res = '1; dz = 1'b1; end
      4'b0100: begin res = {A[WIDTH-2:0], 1'b0}; cy = A[WIDTH-1]; end
      4'b0101: begin res = {1'b0, A[WIDTH-1:1]}; cy = A[0]; end
      4'b0110: res = {A[WIDTH-2:0], A[WIDTH-1]};
      4'b0111: res = {A[0], A[WIDTH-1:1]};
      4'b1000: res = A & B;
      4'b1001: res = A | B;
      4'b1010: res = A ^ B;
      4'b1011: res = ~(A | B);
      4'b1100: res = ~(A & B);
      4'b1101: res = ~(A ^ B);
      4'b1110: res = {{(WIDTH-1){1'b0}}, A > B};
      4'b1111: res = {{(WIDTH-1){1'b0}}, A == B};
      default: res = '0;
    endcase
  end

  // prod holds {acc, multiplier} for MUL and {rem, quotient} for DIV
  always_comb begin
    upper = {1'b0, prod[2*WIDTH-1:WIDTH]} +
            (prod[0] ? {1'b0, opnd} : '0);
    sh    = prod[2*WIDTH-1:WIDTH-1];
    diff  = sh - {1'b0, opnd};
    if (op_div) begin
      if (diff[WIDTH])
        prod_nx = {sh[WIDTH-1:0], prod[WIDTH-2:0], 1'b0};
      else
        prod_nx = {diff[WIDTH-1:0], prod[WIDTH-2:0], 1'b1};
    end else begin
      prod_nx = {upper, prod[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      op_div   <= 1'b0;
      opnd     <= '0;
      prod     <= '0;
      ALU_Out  <= '0;
      CarryOut <= 1'b0;
      Zero     <= 1'b0;
      DivZero  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            if (is_long) begin
              state  <= BUSY;
              cnt    <= '0;
              op_div <= ALU_Sel[0];
              opnd   <= ALU_Sel[0] ? B : A;
              prod   <= {{WIDTH{1'b0}}, (ALU_Sel[0] ? A : B)};
            end else begin
              state    <= DONE;
              ALU_Out  <= res;
              CarryOut <= cy;
              Zero     <= (res == '0);
              DivZero  <= dz;
            end
          end
        end
        BUSY: begin
          prod <= prod_nx;
          cnt  <= cnt + CW'(1);
          if (cnt == CW'(WIDTH-1)) begin
            state    <= DONE;
            cnt      <= '0;
            ALU_Out  <= prod_nx[WIDTH-1:0];
            CarryOut <= !op_div && (prod_nx[2*WIDTH-1:WIDTH] != '0);
            Zero     <= (prod_nx[WIDTH-1:0] == '0);
            DivZero  <= 1'b0;
          end
        end
        DONE: begin
          if (out_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Randomized bench for alu_seq against an arithmetic reference model,
// plus directed cases with literal expectations.
module tb_alu_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [3:0]   ALU_Sel;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] ALU_Out;
  logic         CarryOut;
  logic         Zero;
  logic         DivZero;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .A(A),
    .B(B),
    .ALU_Sel(ALU_Sel),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .ALU_Out(ALU_Out),
    .CarryOut(CarryOut),
    .Zero(Zero),
    .DivZero(DivZero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] w;
    logic       c;
    logic       z;
    logic       dz;
    int         lat;
    int         acc;
    bit         seen;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int passes = 0;
  int cyc = 0;
  bit armed = 0;
  bit rst_prev = 0;
  logic [10:0] last = '0;

  logic [7:0] got_w;
  logic       got_c;
  logic       got_z;
  logic       got_dz;
  int         got_lat;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b,
                                 input logic [3:0] op);
    exp_t e;
    int unsigned ai = a;
    int unsigned bi = b;
    int unsigned r = 0;
    e.c = 0; e.dz = 0; e.lat = 1; e.seen = 0; e.acc = 0;
    case (op)
      4'd0:  begin r = ai + bi; e.c = (r > 255); end
      4'd1:  begin r = ai - bi; e.c = (ai < bi); end
      4'd2:  begin r = ai * bi; e.c = (r > 255); e.lat = 9; end
      4'd3:  begin
        if (bi == 0) begin r = 255; e.dz = 1; end
        else begin r = ai / bi; e.lat = 9; end
      end
      4'd4:  begin r = ai * 2; e.c = (ai >= 128); end
      4'd5:  begin r = ai / 2; e.c = ai % 2; end
      4'd6:  r = ai * 2 + ai / 128;
      4'd7:  r = ai / 2 + (ai % 2) * 128;
      4'd8:  r = ai & bi;
      4'd9:  r = ai | bi;
      4'd10: r = ai ^ bi;
      4'd11: r = ~(ai | bi);
      4'd12: r = ~(ai & bi);
      4'd13: r = ~(ai ^ bi);
      4'd14: r = (ai > bi) ? 1 : 0;
      default: r = (ai == bi) ? 1 : 0;
    endcase
    e.w = 8'(r % 256);
    e.z = (e.w == 0);
    return e;
  endfunction

  always @(posedge clk) cyc++;

  // compare process: every negedge
  always @(negedge clk) begin
    exp_t e;
    if (rst_prev) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_outputs", {ALU_Out, CarryOut, Zero, DivZero}, 0);
    end else if (armed) begin
      chk("in_ready", in_ready, q.size() == 0);
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_valid", 1, 0);
        end else begin
          chk("alu_out", ALU_Out, q[0].w);
          chk("carry", CarryOut, q[0].c);
          chk("zero", Zero, q[0].z);
          chk("divzero", DivZero, q[0].dz);
          if (!q[0].seen) chk("latency", cyc - q[0].acc, q[0].lat);
          q[0].seen = 1;
          last = {q[0].w, q[0].c, q[0].z, q[0].dz};
          if (out_ready) void'(q.pop_front());
        end
      end else begin
        chk("hold_outputs", {ALU_Out, CarryOut, Zero, DivZero}, last);
        if (q.size() > 0 && cyc - q[0].acc > q[0].lat) begin
          chk("result_timeout", 0, 1);
          void'(q.pop_front());
        end
      end
    end
    if (!rst_n) begin
      q.delete();
      last = '0;
      armed = 1;
    end else if (armed && in_valid && in_ready) begin
      e = model(A, B, ALU_Sel);
      e.acc = cyc;
      q.push_back(e);
    end
    rst_prev = !rst_n;
  end

  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input logic [3:0] op, input int hold);
    int n;
    @(posedge clk); #1;
    A = a; B = b; ALU_Sel = op; in_valid = 1'b1;
    out_ready = (hold == 0);
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (!in_ready) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    A = W'($urandom); B = W'($urandom); ALU_Sel = 4'($urandom);
    got_lat = 1;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 50) begin @(negedge clk); got_lat++; n++; end
    if (!out_valid) chk("valid_timeout", 0, 1);
    got_w = ALU_Out; got_c = CarryOut; got_z = Zero; got_dz = DivZero;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      A = W'($urandom); B = W'($urandom); ALU_Sel = 4'($urandom);
    end
    if (hold > 0) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      out_ready = 1'b1;
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    A = '0; B = '0; ALU_Sel = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    run_op(8'hA5, 8'h5A, 4'b1001, 0);
    chk("or_w", got_w, 8'hFF);
    chk("or_c", got_c, 0);
    chk("or_z", got_z, 0);
    chk("or_lat", got_lat, 1);

    run_op(8'hFF, 8'h01, 4'b0000, 0);
    chk("add_w", got_w, 8'h00);
    chk("add_c", got_c, 1);
    chk("add_z", got_z, 1);

    run_op(8'h03, 8'h05, 4'b0001, 0);
    chk("sub_w", got_w, 8'hFE);
    chk("sub_c", got_c, 1);

    run_op(8'h10, 8'h20, 4'b0010, 0);
    chk("mul_w", got_w, 8'h00);
    chk("mul_c", got_c, 1);
    chk("mul_lat", got_lat, 9);

    run_op(8'd100, 8'd7, 4'b0011, 0);
    chk("div_w", got_w, 8'd14);
    chk("div_lat", got_lat, 9);
    chk("div_dz", got_dz, 0);

    run_op(8'd100, 8'd0, 4'b0011, 0);
    chk("div0_w", got_w, 8'hFF);
    chk("div0_dz", got_dz, 1);
    chk("div0_c", got_c, 0);
    chk("div0_lat", got_lat, 1);

    run_op(8'h81, 8'h00, 4'b0100, 5);
    chk("shl_w", got_w, 8'h02);
    chk("shl_c", got_c, 1);

    // abort a multiply in its fourth busy cycle
    @(posedge clk); #1;
    A = 8'h10; B = 8'h20; ALU_Sel = 4'b0010; in_valid = 1'b1;
    @(negedge clk);
    for (int n = 0; n < 50 && !in_ready; n++) @(negedge clk);
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (12) @(posedge clk);

    run_op(8'h01, 8'h01, 4'b0000, 0);
    chk("post_rst_add", got_w, 8'h02);

    // accept attempt during reset is discarded
    @(posedge clk); #1;
    rst_n = 1'b0; in_valid = 1'b1; A = 8'h07; B = 8'h01; ALU_Sel = 4'b0000;
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0;
    repeat (4) @(posedge clk);

    for (int i = 0; i < 300; i++) begin
      logic [3:0] op;
      logic [7:0] a;
      logic [7:0] b;
      op = 4'($urandom_range(0, 15));
      a = 8'($urandom);
      b = 8'($urandom);
      if (op == 4'd3 && $urandom_range(0, 3) == 0) b = 8'h00;
      if ($urandom_range(0, 7) == 0) b = a;
      run_op(a, b, op, $urandom_range(0, 3));
    end

    repeat (12) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
